capture_ctrl: RTL

Capture controller for the logic-analyzer front end. It consumes the qualified protocol trigger (`protTrig`) and the channel trigger. It sequences a circular sample capture: pre-trigger fill, arm, trigger, post-trigger count, done. It drives the write strobe and address of the sample RAM and reports `capture_done` and the trace end address back to the command/config logic.

---
 rtl/capture_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/capture_ctrl.sv
// capture_ctrl
//
// Sequences one circular sample capture for the logic-analyzer front end:
// pre-trigger fill, wait for a qualified trigger, count post-trigger samples,
// then hold the finished trace until it is acknowledged.
//
// Ports
//   clk           sole clock
//   rst           synchronous, active-high reset
//   start         one-cycle capture request (honoured only in IDLE)
//   clr_done      one-cycle acknowledge of a finished capture (DONE -> IDLE)
//   trig_sel      bit0 enables protTrig, bit1 enables chTrig
//   protTrig      protocol trigger level
//   chTrig        channel trigger level
//   smpl_en       sample strobe, one sample per high cycle
//   trig_pos      post-trigger sample count (trigger sample excluded)
//   we            sample RAM write enable (combinational from smpl_en)
//   waddr         sample RAM write address
//   armed         high while waiting for the trigger
//   triggered     high from the cycle after the trigger sample until IDLE
//   capture_done  high while a finished trace is held
//   trace_end     address of the last sample of the finished trace
module capture_ctrl #(
    parameter int ENTRIES = 384,
    parameter int ADDR_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clr_done,
    input  logic [1:0]        trig_sel,
    input  logic              protTrig,
    input  logic              chTrig,
    input  logic              smpl_en,
    input  logic [ADDR_W-1:0] trig_pos,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trace_end
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t            state_reg;
    logic [ADDR_W-1:0] tp_reg;
    logic [ADDR_W-1:0] pre_cnt_reg;
    logic [ADDR_W-1:0] post_cnt_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [ADDR_W-1:0] trace_end_reg;
    logic              triggered_reg;

    logic              trig_hit;
    logic [ADDR_W-1:0] tp_next;
    logic [ADDR_W-1:0] waddr_next;
    logic [ADDR_W-1:0] pre_cnt_next;
    logic [ADDR_W-1:0] post_cnt_next;
    logic [ADDR_W-1:0] pre_target;

    assign trig_hit      = (trig_sel[0] & protTrig) | (trig_sel[1] & chTrig);
    // Post-trigger length can never exceed the RAM: one slot is the trigger.
    assign tp_next       = (trig_pos > LAST) ? LAST : trig_pos;
    // Address wraps at ENTRIES, not at 2**ADDR_W, so unused slots are never hit.
    assign waddr_next    = (waddr_reg == LAST) ? '0 : waddr_reg + ONE;
    assign pre_cnt_next  = pre_cnt_reg + ONE;
    assign post_cnt_next = post_cnt_reg + ONE;
    // Pre-fill length so that pre + trigger + post fills the RAM exactly.
    assign pre_target    = LAST - tp_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            tp_reg        <= '0;
            pre_cnt_reg   <= '0;
            post_cnt_reg  <= '0;
            waddr_reg     <= '0;
            trace_end_reg <= '0;
            triggered_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        tp_reg       <= tp_next;
                        waddr_reg    <= '0;
                        pre_cnt_reg  <= '0;
                        post_cnt_reg <= '0;
                        // No pre-fill needed when the whole RAM is post-trigger.
                        state_reg    <= (tp_next == LAST) ? ARMED : PRE;
                    end
                end
                PRE: begin
                    if (smpl_en) begin
                        waddr_reg   <= waddr_next;
                        pre_cnt_reg <= pre_cnt_next;
                        if (pre_cnt_next == pre_target) begin
                            state_reg <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (smpl_en) begin
                        waddr_reg <= waddr_next;
                        if (trig_hit) begin
                            triggered_reg <= 1'b1;
                            if (tp_reg == '0) begin
                                trace_end_reg <= waddr_reg;
                                state_reg     <= DONE;
                            end else begin
                                state_reg <= POST;
                            end
                        end
                    end
                end
                POST: begin
                    if (smpl_en) begin
                        waddr_reg    <= waddr_next;
                        post_cnt_reg <= post_cnt_next;
                        if (post_cnt_next == tp_reg) begin
                            trace_end_reg <= waddr_reg;
                            state_reg     <= DONE;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here, even with clr_done.
                    if (clr_done) begin
                        state_reg     <= IDLE;
                        triggered_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign we           = smpl_en & ((state_reg == PRE) | (state_reg == ARMED) |
                                     (state_reg == POST));
    assign waddr        = waddr_reg;
    assign armed        = (state_reg == ARMED);
    assign triggered    = triggered_reg;
    assign capture_done = (state_reg == DONE);
    assign trace_end    = trace_end_reg;

endmodule
